// File: rtl/pipelined_alu.sv
// Three-cycle fixed-latency, fully pipelined five-operand ALU.
// Stage 1 captures operands, stage 2 sorts/sums/differences,
// stage 3 forms the median*max product, output stage muxes and divides.
module pipelined_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] mode,
  input  logic [4:0] in_number1,
  input  logic [4:0] in_number2,
  input  logic [4:0] in_number3,
  input  logic [4:0] in_number4,
  input  logic [4:0] in_number5,
  output logic       out_valid,
  output logic [9:0] out_number
);

  localparam int unsigned OW = 5;   // operand width
  localparam int unsigned RW = 10;  // result width
  localparam int unsigned TW = 7;   // width of the three-operand trimmed sum
  localparam int unsigned NOP = 5;  // number of operands

  // stage 1 state
  logic          v1;
  logic [1:0]    m1;
  logic [OW-1:0] n1_q [NOP];

  // stage 2 state
  logic          v2;
  logic [1:0]    m2;
  logic [RW-1:0] sum2;
  logic [RW-1:0] diff2;
  logic [OW-1:0] med2;
  logic [OW-1:0] max2;
  logic [TW-1:0] tsum2;

  // stage 3 state
  logic          v3;
  logic [1:0]    m3;
  logic [RW-1:0] sum3;
  logic [RW-1:0] diff3;
  logic [RW-1:0] prod3;
  logic [TW-1:0] tsum3;

  // combinational helpers
  logic [OW-1:0] srt [NOP];
  logic [OW-1:0] tmp;
  logic [RW-1:0] sum_c;
  logic [RW-1:0] prod_a_c;
  logic [RW-1:0] prod_b_c;
  logic [RW-1:0] diff_c;
  logic [TW-1:0] tsum_c;
  logic [RW-1:0] result_c;

  // capture a valid operand set; valid bit is cleared on idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      m1 <= '0;
      for (int i = 0; i < int'(NOP); i++) n1_q[i] <= '0;
    end else begin
      v1 <= in_valid;
      m1 <= mode;
      n1_q[0] <= in_number1;
      n1_q[1] <= in_number2;
      n1_q[2] <= in_number3;
      n1_q[3] <= in_number4;
      n1_q[4] <= in_number5;
    end
  end

  // ascending bubble-sort network over the captured operands
  always_comb begin
    tmp = '0;
    for (int i = 0; i < int'(NOP); i++) srt[i] = n1_q[i];
    for (int i = 0; i < int'(NOP) - 1; i++) begin
      for (int j = 0; j < int'(NOP) - 1 - i; j++) begin
        if (srt[j] > srt[j+1]) begin
          tmp      = srt[j];
          srt[j]   = srt[j+1];
          srt[j+1] = tmp;
        end
      end
    end
  end

  // plain sum, trimmed sum and absolute product difference
  always_comb begin
    sum_c    = RW'(n1_q[0]) + RW'(n1_q[1]) + RW'(n1_q[2]) + RW'(n1_q[3]) + RW'(n1_q[4]);
    tsum_c   = TW'(srt[1]) + TW'(srt[2]) + TW'(srt[3]);
    prod_a_c = RW'(n1_q[0]) * RW'(n1_q[1]);
    prod_b_c = RW'(n1_q[2]) * RW'(n1_q[3]);
    diff_c   = (prod_a_c >= prod_b_c) ? (prod_a_c - prod_b_c) : (prod_b_c - prod_a_c);
  end

  // stage 2 register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      m2    <= '0;
      sum2  <= '0;
      diff2 <= '0;
      med2  <= '0;
      max2  <= '0;
      tsum2 <= '0;
    end else begin
      v2    <= v1;
      m2    <= m1;
      sum2  <= sum_c;
      diff2 <= diff_c;
      med2  <= srt[2];
      max2  <= srt[4];
      tsum2 <= tsum_c;
    end
  end

  // stage 3 register: median times maximum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3    <= 1'b0;
      m3    <= '0;
      sum3  <= '0;
      diff3 <= '0;
      prod3 <= '0;
      tsum3 <= '0;
    end else begin
      v3    <= v2;
      m3    <= m2;
      sum3  <= sum2;
      diff3 <= diff2;
      prod3 <= RW'(med2) * RW'(max2);
      tsum3 <= tsum2;
    end
  end

  // mode select and floor divide-by-3 of the trimmed sum
  always_comb begin
    result_c = '0;
    case (m3)
      2'd0:    result_c = sum3;
      2'd1:    result_c = prod3;
      2'd2:    result_c = diff3;
      default: result_c = RW'(tsum3 / TW'(3));
    endcase
  end

  // output register; result forced to zero when nothing is due
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_number <= '0;
    end else begin
      out_valid  <= v3;
      out_number <= v3 ? result_c : '0;
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed vector table, hand-written
// gap and reset sequences, and random sets checked against a reference model.
module tb_pipelined_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] mode;
  logic [4:0] in_number1, in_number2, in_number3, in_number4, in_number5;
  logic       out_valid;
  logic [9:0] out_number;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cyc = 0;
  int unsigned cur_exp = 0;

  typedef struct {
    int unsigned due;
    int unsigned value;
  } pend_t;
  pend_t pend[$];

  typedef struct {
    logic [1:0]  md;
    logic [4:0]  a, b, c, d, e;
    int unsigned exp;
  } vec_t;
  vec_t vecs[12];

  pipelined_alu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .in_number1(in_number1), .in_number2(in_number2), .in_number3(in_number3),
    .in_number4(in_number4), .in_number5(in_number5),
    .out_valid(out_valid), .out_number(out_number)
  );

  always #5 clk = ~clk;

  // k-th smallest (0-based) by rank counting, duplicates kept
  function automatic int unsigned kth(input int unsigned v[5], input int k);
    int lt, le;
    for (int i = 0; i < 5; i++) begin
      lt = 0; le = 0;
      for (int j = 0; j < 5; j++) begin
        if (v[j] < v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= k && k < le) return v[i];
    end
    return 0;
  endfunction

  function automatic int unsigned model(input int unsigned md, input int unsigned v[5]);
    int unsigned p, q;
    case (md)
      0: return v[0] + v[1] + v[2] + v[3] + v[4];
      1: return kth(v, 2) * kth(v, 4);
      2: begin
        p = v[0] * v[1];
        q = v[2] * v[3];
        return (p > q) ? p - q : q - p;
      end
      default: return (kth(v, 1) + kth(v, 2) + kth(v, 3)) / 3;
    endcase
  endfunction

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
  endtask

  // one clock: record what the edge accepts, then check outputs on the falling edge
  task automatic tick();
    bit          ev;
    int unsigned en;
    @(posedge clk);
    cyc++;
    if (!rst_n) pend.delete();
    else if (in_valid) pend.push_back('{due: cyc + 3, value: cur_exp});
    @(negedge clk);
    ev = 1'b0;
    en = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1'b1;
      en = pend[0].value;
      void'(pend.pop_front());
    end
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_number", 32'(out_number), en);
  endtask

  task automatic drive(input logic [1:0] md, input logic [4:0] a, b, c, d, e, input int unsigned exp);
    in_valid = 1'b1;
    mode = md;
    in_number1 = a; in_number2 = b; in_number3 = c; in_number4 = d; in_number5 = e;
    cur_exp = exp;
  endtask

  task automatic idle_rand();
    in_valid = 1'b0;
    mode = 2'($urandom);
    in_number1 = 5'($urandom); in_number2 = 5'($urandom); in_number3 = 5'($urandom);
    in_number4 = 5'($urandom); in_number5 = 5'($urandom);
    cur_exp = 0;
  endtask

  task automatic drive_rand();
    int unsigned v[5];
    logic [1:0]  md;
    md = 2'($urandom);
    for (int i = 0; i < 5; i++) v[i] = $urandom_range(0, 31);
    drive(md, 5'(v[0]), 5'(v[1]), 5'(v[2]), 5'(v[3]), 5'(v[4]), model(32'(md), v));
  endtask

  initial begin
    vecs[0]  = '{2'd0, 5'd1,  5'd2,  5'd3, 5'd4,  5'd5,  15};
    vecs[1]  = '{2'd0, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 155};
    vecs[2]  = '{2'd1, 5'd3,  5'd17, 5'd9, 5'd30, 5'd1,  270};
    vecs[3]  = '{2'd3, 5'd3,  5'd17, 5'd9, 5'd30, 5'd1,  9};
    vecs[4]  = '{2'd1, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 961};
    vecs[5]  = '{2'd2, 5'd2,  5'd3,  5'd4, 5'd5,  5'd19, 14};
    vecs[6]  = '{2'd2, 5'd31, 5'd31, 5'd0, 5'd5,  5'd7,  961};
    vecs[7]  = '{2'd2, 5'd4,  5'd4,  5'd2, 5'd8,  5'd23, 0};
    vecs[8]  = '{2'd0, 5'd3,  5'd17, 5'd9, 5'd30, 5'd1,  60};
    vecs[9]  = '{2'd1, 5'd3,  5'd17, 5'd9, 5'd30, 5'd1,  270};
    vecs[10] = '{2'd2, 5'd3,  5'd17, 5'd9, 5'd30, 5'd1,  219};
    vecs[11] = '{2'd3, 5'd3,  5'd17, 5'd9, 5'd30, 5'd1,  9};

    // reset held with valid random inputs, then idle after release
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_rand();
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_rand();
      tick();
    end

    // each directed vector in isolation
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].e, vecs[i].exp);
      tick();
      for (int k = 0; k < 4; k++) begin
        idle_rand();
        tick();
      end
    end

    // mixed modes back to back
    for (int i = 8; i < 12; i++) begin
      drive(vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].e, vecs[i].exp);
      tick();
    end
    idle_rand();
    for (int k = 0; k < 4; k++) tick();

    // same stream with a one-cycle gap after the second set
    for (int i = 8; i < 12; i++) begin
      drive(vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].e, vecs[i].exp);
      tick();
      if (i == 9) begin
        idle_rand();
        tick();
      end
    end
    idle_rand();
    for (int k = 0; k < 4; k++) tick();

    // reset in mid-stream discards three in-flight sets
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    rst_n = 1'b0;
    drive_rand();
    tick();
    rst_n = 1'b1;
    idle_rand();
    for (int k = 0; k < 3; k++) tick();
    drive(vecs[2].md, vecs[2].a, vecs[2].b, vecs[2].c, vecs[2].d, vecs[2].e, vecs[2].exp);
    tick();
    idle_rand();
    for (int k = 0; k < 4; k++) tick();

    // random stream with random gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_rand();
      else idle_rand();
      tick();
    end
    idle_rand();
    for (int k = 0; k < 5; k++) tick();
    check("drained", pend.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
